// File: rtl/fft8_bitrev_loader.sv
// fft8_bitrev_loader: ping-pong loader that reorders 8-sample frames into bit-reversed order
// Ports: clk/rst (async active-high); in_data/in_valid/in_last/in_ready serial input stream;
// o0..o7/out_valid/out_ready parallel frame output; sync_err sticky framing error.
module fft8_bitrev_loader #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] o0,
    output logic [DW-1:0] o1,
    output logic [DW-1:0] o2,
    output logic [DW-1:0] o3,
    output logic [DW-1:0] o4,
    output logic [DW-1:0] o5,
    output logic [DW-1:0] o6,
    output logic [DW-1:0] o7,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sync_err
);
    logic [DW-1:0] bank [2][8];
    logic [1:0]    bank_full;
    logic          wr_bank, rd_bank;
    logic [2:0]    wr_idx;
    logic          acc, cons;
    assign in_ready  = !rst && !bank_full[wr_bank];
    assign acc       = in_valid && in_ready;
    assign out_valid = bank_full[rd_bank];
    assign cons      = out_valid && out_ready;
    assign o0 = bank[rd_bank][0];
    assign o1 = bank[rd_bank][1];
    assign o2 = bank[rd_bank][2];
    assign o3 = bank[rd_bank][3];
    assign o4 = bank[rd_bank][4];
    assign o5 = bank[rd_bank][5];
    assign o6 = bank[rd_bank][6];
    assign o7 = bank[rd_bank][7];
    // acc only touches a non-full write bank and cons only a full read bank, so the
    // two bank_full updates below never target the same bit in one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < 8; k++)
                    bank[b][k] <= '0;
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            sync_err  <= 1'b0;
        end else begin
            if (acc) begin
                bank[wr_bank][{wr_idx[0], wr_idx[1], wr_idx[2]}] <= in_data;
                wr_idx <= wr_idx + 3'd1;
                if (in_last != (wr_idx == 3'd7))
                    sync_err <= 1'b1;
                if (wr_idx == 3'd7) begin
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                end
            end
            if (cons) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end
endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// tb_fft8_bitrev_loader: directed self-checking bench for fft8_bitrev_loader
module tb_fft8_bitrev_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, sync_err;
    logic [63:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [63:0] o [8];
    int n_cmp = 0, n_err = 0;
    logic [31:0] re [8] = '{32'h00000000, 32'h3f800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40a00000, 32'h40c00000, 32'h40e00000};
    int rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft8_bitrev_loader #(.DW(64)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5),
        .o6(o6), .o7(o7), .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err)
    );

    always #5 clk = ~clk;
    assign o[0] = o0; assign o[1] = o1; assign o[2] = o2; assign o[3] = o3;
    assign o[4] = o4; assign o[5] = o5; assign o[6] = o6; assign o[7] = o7;

    function automatic logic [63:0] smp(input int f, input int n);
        return {re[n], 32'(f)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input int f);
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_o%0d", tag, k), o[k], smp(f, rev[k]));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int f, input int n, input logic last);
        in_valid = 1'b1;
        in_data  = smp(f, n);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_o0", o0, 0);
        chk("rst_err", sync_err, 0);
        rst = 1'b0;
        #1;
        chk("rel_ready", in_ready, 1);
        tick();
        // single frame, natural float values
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            send(0, n, n == 7);
            chk($sformatf("t1_valid%0d", n), out_valid, n == 7);
        end
        chk_frame("t1", 0);
        chk("t1_o1_x4", o1, 64'h4080000000000000);
        chk("t1_o4_x1", o4, 64'h3f80000000000000);
        chk("t1_err", sync_err, 0);
        tick();
        chk("t1_consumed", out_valid, 0);
        // two frames back-to-back with downstream stalled
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_ready%0d", i), in_ready, 1);
            send(1 + i / 8, i % 8, i % 8 == 7);
            if (i == 8) chk_frame("t2_holdA", 1);
        end
        chk("t2_full_ready", in_ready, 0);
        chk("t2_valid", out_valid, 1);
        chk_frame("t2_A", 1);
        in_valid = 1'b1;
        in_data  = smp(99, 0);
        tick();
        tick();
        chk("t2_blocked_ready", in_ready, 0);
        chk_frame("t2_A_kept", 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("t2_B_valid", out_valid, 1);
        chk("t2_B_ready", in_ready, 1);
        chk_frame("t2_B", 2);
        out_ready = 1'b1;
        tick();
        chk("t2_B_consumed", out_valid, 0);
        // three continuous frames at full rate
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("t3_ready%0d", i), in_ready, 1);
            send(3 + i / 8, i % 8, i % 8 == 7);
            chk($sformatf("t3_valid%0d", i), out_valid, i % 8 == 7);
            if (i % 8 == 7) chk_frame($sformatf("t3_f%0d", 3 + i / 8), 3 + i / 8);
        end
        tick();
        chk("t3_drained", out_valid, 0);
        // valid every other cycle
        for (int n = 0; n < 8; n++) begin
            send(6, n, n == 7);
            if (n < 7) begin
                chk($sformatf("t4_valid%0d", n), out_valid, 0);
                tick();
            end
        end
        chk("t4_valid", out_valid, 1);
        chk_frame("t4", 6);
        tick();
        // in_last on the wrong sample
        for (int n = 0; n < 8; n++) begin
            send(7, n, n == 5);
            if (n == 4) chk("t5_err_pre", sync_err, 0);
            if (n == 5) chk("t5_err_set", sync_err, 1);
        end
        chk("t5_err_sticky", sync_err, 1);
        chk("t5_valid", out_valid, 1);
        chk_frame("t5", 7);
        tick();
        chk("t5_err_still", sync_err, 1);
        // reset with one frame held and a partial frame loading
        out_ready = 1'b0;
        for (int n = 0; n < 8; n++) send(8, n, n == 7);
        for (int n = 0; n < 5; n++) send(9, n, 1'b0);
        chk("t6_held_valid", out_valid, 1);
        chk_frame("t6_held", 8);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 0);
        chk("t6_rst_err", sync_err, 0);
        for (int k = 0; k < 8; k++) chk($sformatf("t6_rst_o%0d", k), o[k], 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rel_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) send(10, n, n == 7);
        chk("t6_valid", out_valid, 1);
        chk_frame("t6_fresh", 10);
        chk("t6_err", sync_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fft8_bitrev_loader.md
Name: fft8_bitrev_loader

Overview:
- Upstream input stage of the 8-point radix-2 FFT pipeline.
- Accepts one complex sample per cycle over a valid/ready stream and reorders each 8-sample frame into bit-reversed order.
- Presents the whole frame in parallel as o0..o7 to the first butterfly stage.
- Ping-pong double buffering: the next frame loads while the current frame is held for the downstream stage.

Parameters:
- DW, 64, complex sample width; upper DW/2 bits = real (IEEE-754 single), lower DW/2 bits = imaginary. Data is opaque to this block and never modified.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  DW  serial input sample, natural order x0..x7
- in_valid  in  1  in_data valid
- in_last  in  1  marks the final sample (x7) of a frame; used for checking only
- in_ready  out  1  block can accept a sample this cycle
- o0..o7  out  DW each  parallel frame in bit-reversed order
- out_valid  out  1  o0..o7 hold a complete frame
- out_ready  in  1  downstream consumes the frame
- sync_err  out  1  sticky in_last framing error flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- State:
  - two banks of 8 x DW registers
  - bank_full[1:0]
  - wr_bank, rd_bank (1 bit each)
  - wr_idx (3 bits)
  - sync_err
- Reset (async assert): all bank registers = 0, bank_full = 0, wr_bank = rd_bank = 0, wr_idx = 0, sync_err = 0. Hence out_valid = 0 and o0..o7 = 0.
- in_ready = !rst && !bank_full[wr_bank] (combinational from registers only, no path from in_valid or out_ready).
- Accept = in_valid && in_ready.
- On accept:
  - bank[wr_bank][bitrev3(wr_idx)] <= in_data
  - wr_idx <= wr_idx + 1 (wraps 7 -> 0)
- Bit-reverse map, sample -> slot: x0->0, x1->4, x2->2, x3->6, x4->1, x5->5, x6->3, x7->7.
- Resulting outputs: o0=x0, o1=x4, o2=x2, o3=x6, o4=x1, o5=x5, o6=x3, o7=x7.
- Accept with wr_idx == 7: bank_full[wr_bank] <= 1 and wr_bank toggles in the same edge.
- Outputs:
  - out_valid = bank_full[rd_bank]
  - ok = bank[rd_bank][k]
  - All are register outputs. They are stable while out_valid = 1 and not yet consumed.
- Consume = out_valid && out_ready. On consume: bank_full[rd_bank] <= 0 and rd_bank toggles. Bank contents are not cleared.
- Latency: 8th sample accepted at edge t -> out_valid = 1 after edge t (visible in cycle t+1), provided the read bank is that bank.
- Throughput: sustained 1 sample/cycle with no in_ready gaps while out_ready is held 1.
- Simultaneous fill-complete of one bank and consume of the other: both take effect in the same edge.
- The same bank can never be set and cleared in one edge, because writes to a full bank are blocked.
- Both banks full: in_ready = 0, wr_idx holds, and in_data is ignored until a consume. in_ready rises the cycle after that consume.
- in_valid deasserted mid-frame: wr_idx holds. There is no timeout and no partial-frame flush.
- Framing check:
  - On accept, if in_last != (wr_idx == 7), then sync_err <= 1. It stays set until rst.
  - Frame boundaries follow the count only; in_last never resets wr_idx.
- Reset mid-frame or mid-hold: all state returns to reset values immediately (async). Any partial or held frame is discarded.

Test Plan:
- Reset then stream x_n = {real = n, imag = 0} (e.g. x1 = 64'h3f80000000000000, x4 = 64'h4080000000000000) for n = 0..7, in_last on x7, out_ready = 1 -> out_valid = 1 one cycle after x7 accept. o1 = x4, o4 = x1, o3 = x6, o6 = x3; o0/o2/o5/o7 unchanged in position. sync_err = 0.
- out_ready = 0, stream 16 samples back-to-back -> in_ready stays 1 for 16 accepts, then 0. out_valid = 1 showing frame A while frame B loads. One out_ready pulse -> frame B is presented the next cycle and in_ready returns to 1.
- 3 continuous frames with out_ready = 1 and in_valid = 1 every cycle -> in_ready never drops. out_valid pulses once per 8 cycles with correct bit-reversed contents each time.
- in_valid gaps (valid every other cycle) -> identical outputs to the gapless case; wr_idx advances only on accept.
- in_last asserted on sample 5 -> sync_err = 1 after that edge and remains 1. The frame still completes after 8 accepts with correct ordering.
- Assert rst after 5 samples accepted and one full frame held -> out_valid = 0, o0..o7 = 0, and in_ready = 1 after release. A fresh 8-sample frame produces correct output.
